// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular FIFO between the fetch and register stages.
// The head entry is presented combinationally, and a NOP is presented when the queue is empty.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module fetch_decode_queue #(
    parameter int                    DEPTH     = 2,
    parameter logic [`WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       FetchValid,
    output logic                       FetchReady,
    input  logic [`WORD_SIZE-1:0]      InstrF,
    input  logic [`BIT_COUNT-1:0]      PCF,
    output logic                       DecodeValid,
    input  logic                       DecodeReady,
    output logic [`WORD_SIZE-1:0]      InstrD,
    output logic [`BIT_COUNT-1:0]      PCD,
    output logic [`BIT_COUNT-1:0]      PCPlus4D,
    input  logic                       FlushD,
    output logic [$clog2(DEPTH):0]     Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [`WORD_SIZE-1:0] instr;
        logic [`BIT_COUNT-1:0] pc;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  cnt;
    logic           push, pop;

    // Ready depends only on registered occupancy, so a full queue refuses an offer even while popping.
    assign FetchReady  = (cnt < CW'(DEPTH));
    assign DecodeValid = (cnt != '0);
    assign push        = FetchValid && FetchReady && !FlushD;
    assign pop         = DecodeValid && DecodeReady && !FlushD;
    assign Count       = cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (FlushD) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    // Storage is deliberately unreset; entries are only observable while counted valid.
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= '{instr: InstrF, pc: PCF};
    end

    assign head     = mem[rd_ptr];
    assign InstrD   = DecodeValid ? head.instr : NOP_INSTR;
    assign PCD      = DecodeValid ? head.pc    : '0;
    assign PCPlus4D = PCD + `BIT_COUNT'(4);
endmodule
